// File: rtl/dipswitch_ctrl.sv
// Debounced DIP-switch bank: per-group 2-flop synchroniser and debounce filter,
// sticky change flags, interrupt-enable mask and a level interrupt.
module dipswitch_ctrl #(
  parameter int NUM_GROUPS = 8,
  parameter int DB_CYCLES  = 20000,
  parameter int CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [6:2]              Addr,
  input  logic                    WE,
  input  logic [31:0]             WD,
  output logic [31:0]             RD,
  input  logic [8*NUM_GROUPS-1:0] dip_switch,
  output logic                    irq
);
  localparam int W = 8 * NUM_GROUPS;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [W-1:0]          r_sync1;
  logic [W-1:0]          r_sample;
  logic [W-1:0]          r_last;
  logic [W-1:0]          w_stable;
  logic [NUM_GROUPS-1:0] w_commit;
  logic [NUM_GROUPS-1:0] w_clr;
  logic [NUM_GROUPS-1:0] r_chg;
  logic [NUM_GROUPS-1:0] r_ie;
  logic [255:0]          w_data_pad;
  logic [31:0]           w_chg_pad;
  logic [31:0]           w_ie_pad;
  logic                  w_unused_wd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1  <= '0;
      r_sample <= '0;
      r_last   <= '0;
    end else begin
      r_sync1  <= dip_switch;
      r_sample <= r_sync1;
      r_last   <= r_sample;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_GROUPS; gi++) begin : g_grp
      logic [CNT_W-1:0] r_cnt;
      logic [7:0]       r_stable;
      logic [7:0]       w_s;
      logic             w_steady;

      assign w_s      = r_sample[8*gi +: 8];
      // counting only while the sample holds and differs from the accepted value
      assign w_steady = (w_s == r_last[8*gi +: 8]) && (w_s != r_stable);
      assign w_commit[gi] = w_steady && (r_cnt == CNT_LAST);
      assign w_stable[8*gi +: 8] = r_stable;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_cnt    <= '0;
          r_stable <= '0;
        end else if (!w_steady) begin
          r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
          r_stable <= w_s;
          r_cnt    <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  endgenerate

  assign w_clr = (WE && (Addr == 5'd30)) ? WD[NUM_GROUPS-1:0] : '0;

  // a commit on the same edge as a W1C keeps the flag set
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_chg <= '0;
      r_ie  <= '0;
    end else begin
      r_chg <= (r_chg & ~w_clr) | w_commit;
      if (WE && (Addr == 5'd31)) begin
        r_ie <= WD[NUM_GROUPS-1:0];
      end
    end
  end

  always_comb begin
    w_data_pad                  = '0;
    w_data_pad[W-1:0]           = w_stable;
    w_chg_pad                   = '0;
    w_chg_pad[NUM_GROUPS-1:0]   = r_chg;
    w_ie_pad                    = '0;
    w_ie_pad[NUM_GROUPS-1:0]    = r_ie;
  end

  always_comb begin
    RD = '0;
    if (Addr[6:5] == 2'b00) begin
      RD = w_data_pad[{Addr[4:2], 5'b00000} +: 32];
    end else if (Addr == 5'd30) begin
      RD = w_chg_pad;
    end else if (Addr == 5'd31) begin
      RD = w_ie_pad;
    end
  end

  assign irq = |(r_chg & r_ie);

  assign w_unused_wd = &{1'b0, WD};
endmodule
